// File: rtl/async_fifo_pkg.sv
// Shared defaults and Gray/binary pointer conversion helpers for async_fifo.
// Helpers take the pointer width as an argument and operate on zero-extended values.
package async_fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PTR_W_MAX      = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  function automatic ptr_t width_mask(input int unsigned w);
    ptr_t m;
    if (w >= PTR_W_MAX) m = '1;
    else                m = (ptr_t'(1) << w) - ptr_t'(1);
    return m;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t bin, input int unsigned w);
    ptr_t b;
    b = bin & width_mask(w);
    return b ^ (b >> 1);
  endfunction

  // Upper bits are masked to zero, so the MSB-first prefix XOR is correct for any w.
  function automatic ptr_t gray2bin(input ptr_t gray, input int unsigned w);
    ptr_t g;
    ptr_t b;
    g = gray & width_mask(w);
    b = g;
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read-data register is.
module fifo_mem_dp #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read data holds its value when no read is granted.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with Gray-coded pointers and full/empty back-pressure.
// Define FIFO_LEVEL_EN to expose the occupancy count on the level port.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
`ifdef FIFO_LEVEL_EN
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
`else
  output logic                  empty
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  // Inverting the top two Gray bits of the read pointer gives the "one lap ahead" write pointer.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

  logic [PTR_W-1:0] wr_bin_d,  wr_bin_q;
  logic [PTR_W-1:0] wr_gray_d, wr_gray_q;
  logic [PTR_W-1:0] rd_bin_d,  rd_bin_q;
  logic [PTR_W-1:0] rd_gray_d, rd_gray_q;
  logic             wr_go;
  logic             rd_go;

  assign empty = (rd_gray_q == wr_gray_q);
  assign full  = (wr_gray_q == (rd_gray_q ^ FULL_MASK));
  assign wr_go = wr_en && !full;
  assign rd_go = rd_en && !empty;

  always_comb begin
    wr_bin_d  = wr_bin_q;
    rd_bin_d  = rd_bin_q;
    if (wr_go) wr_bin_d = wr_bin_q + PTR_W'(1);
    if (rd_go) rd_bin_d = rd_bin_q + PTR_W'(1);
    wr_gray_d = PTR_W'(bin2gray(ptr_t'(wr_bin_d), PTR_W));
    rd_gray_d = PTR_W'(bin2gray(ptr_t'(rd_bin_d), PTR_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
    end
  end

  fifo_mem_dp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_go),
    .waddr (wr_bin_q[ADDR_WIDTH-1:0]),
    .wdata (din),
    .re    (rd_go),
    .raddr (rd_bin_q[ADDR_WIDTH-1:0]),
    .rdata (dout)
  );

`ifdef FIFO_LEVEL_EN
  assign level = wr_bin_q - rd_bin_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Randomized + directed bench for async_fifo against a queue-based reference model.
// Works with or without FIFO_LEVEL_EN defined.
module tb_async_fifo;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
`ifdef FIFO_LEVEL_EN
  logic [AW:0]   level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue plus the last value popped.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;

  always #5 clk = ~clk;

  async_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
`ifdef FIFO_LEVEL_EN
    .empty (empty),
    .level (level)
`else
    .empty (empty)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_dout = '0;
    end else begin
      bit do_w;
      bit do_r;
      do_w = wr_en && (mq.size() < DEPTH);
      do_r = rd_en && (mq.size() > 0);
      if (do_r) m_dout = mq.pop_front();
      if (do_w) mq.push_back(din);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_full", 32'(full), 32'h0);
    end else begin
      chk("model_dout", 32'(dout), 32'(m_dout));
      chk("model_empty", 32'(empty), 32'(mq.size() == 0));
      chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
`ifdef FIFO_LEVEL_EN
      chk("model_level", 32'(level), 32'(mq.size()));
`endif
      if (full && empty) chk("full_and_empty", 32'h1, 32'h0);
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    #22;
    rst = 1'b0;
    chk("init_empty", 32'(empty), 32'h1);
    chk("init_full", 32'(full), 32'h0);
    chk("init_dout", 32'(dout), 32'h0);

    // Basic order
    for (int i = 0; i < 14; i++) begin
      step(1'b1, DW'(8'hA0 + i), 1'b0);
      chk("basic_wr_full", 32'(full), 32'h0);
    end
    chk("basic_not_empty", 32'(empty), 32'h0);
    idle(4);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, '0, 1'b1);
      chk("basic_rd", 32'(dout), 32'(8'hA0 + i));
    end
    idle(1);
    chk("basic_empty_after", 32'(empty), 32'h1);

    // Full prevention
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(8'hB0 + i), 1'b0);
      chk("fill_full", 32'(full), 32'(i >= 15));
    end
`ifdef FIFO_LEVEL_EN
    chk("fill_level16", 32'(level), 32'd16);
`endif

    // Empty prevention
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_dout", 32'(dout), (i < 16) ? 32'(8'hB0 + i) : 32'hBF);
      chk("drain_empty", 32'(empty), 32'(i >= 15));
    end

    // Wrap-around laps
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 16; i++) step(1'b1, DW'(lap * 16 + i), 1'b0);
      chk("lap_full", 32'(full), 32'h1);
      for (int i = 0; i < 16; i++) begin
        step(1'b0, '0, 1'b1);
        chk("lap_rd", 32'(dout), 32'(lap * 16 + i));
      end
      chk("lap_empty", 32'(empty), 32'h1);
    end

    // Simultaneous access mid-occupancy
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h60 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(8'h70 + i), 1'b1);
      chk("sim_rd", 32'(dout), (i < 5) ? 32'(8'h60 + i) : 32'(8'h70 + i - 5));
`ifdef FIFO_LEVEL_EN
      chk("sim_level", 32'(level), 32'd5);
`endif
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1);
      chk("sim_drain", 32'(dout), 32'(8'h75 + i));
    end

    // Simultaneous at full: read only
    for (int i = 0; i < 16; i++) step(1'b1, DW'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("full_both_dout", 32'(dout), 32'h80);
    chk("full_both_full", 32'(full), 32'h0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, '0, 1'b1);
      chk("full_both_drain", 32'(dout), 32'(8'h81 + i));
    end
    chk("full_both_empty", 32'(empty), 32'h1);

    // Simultaneous at empty: write only, no bypass
    step(1'b1, 8'h33, 1'b1);
    chk("empty_both_dout", 32'(dout), 32'h8F);
    chk("empty_both_empty", 32'(empty), 32'h0);
    step(1'b0, '0, 1'b1);
    chk("empty_both_rd", 32'(dout), 32'h33);

    // Reset mid-operation
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8'hC0 + i), 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_empty", 32'(empty), 32'h1);
    chk("midrst_full", 32'(full), 32'h0);
    chk("midrst_dout", 32'(dout), 32'h0);
    #2 rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("midrst_rd", 32'(dout), 32'h5A);
    idle(1);

    // Randomized traffic with varying pressure and occasional reset
    for (int blk = 0; blk < 12; blk++) begin
      int wp;
      int rp;
      wp = 10 + 35 * (blk % 3);
      rp = 80 - 35 * ((blk / 3) % 3);
      for (int c = 0; c < 200; c++) begin
        step(32'($urandom_range(0, 99)) < 32'(wp), DW'($urandom), 32'($urandom_range(0, 99)) < 32'(rp));
      end
      if (blk == 5) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    wr_en = 1'b0;
    rd_en = 1'b0;
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
